// File: rtl/clrset_pkg.sv
// Shared op codes, FSM state encoding and statistics width for clrset_pulser.
package clrset_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPulse = 2'b01,
    StRecov = 2'b10,
    StLoad  = 2'b11
  } state_e;

endpackage

// File: rtl/clrset_pulser_pw_cnt.sv
// Loadable down-counter with zero flag; shared by the pulse-width and recovery phases.
module pw_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clrset_pulser.sv
// Clear/set pulse and load-strobe sequencer for a dff register.
// Optional completed-op counter on cnt_o when CLRSET_PULSER_STAT_EN is defined.
module clrset_pulser
  import clrset_pkg::*;
#(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned PW_BITS   = 4,
  parameter int unsigned RECOV_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [PW_BITS-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             clr_o,
  output logic             set_o,
  output logic             ld_o,
  output logic [WIDTH-1:0] d_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned RW = $clog2(RECOV_CYC + 1);
  localparam int unsigned CW = (PW_BITS > RW) ? PW_BITS : RW;
  localparam logic [CW-1:0] RECOV_LD = CW'(RECOV_CYC - 1);

  state_e state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic clr_q, clr_d, set_q, set_d, ld_q, ld_d;
  logic [WIDTH-1:0] d_q, d_d;

  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_val, len_m1;

  // A zero length is treated as a single-cycle pulse.
  assign len_m1 = (len_i == '0) ? '0 : CW'(len_i - PW_BITS'(1));

  pw_cnt #(
    .W (CW)
  ) u_pw_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ld_d     = 1'b0;
    clr_d    = clr_q;
    set_d    = set_q;
    d_d      = d_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = len_m1;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          unique case (op_i)
            OP_LOAD: begin
              state_d = StLoad;
              ld_d    = 1'b1;
              d_d     = data_i;
            end
            OP_CLR: begin
              state_d  = StPulse;
              clr_d    = 1'b1;
              cnt_load = 1'b1;
            end
            OP_SET: begin
              state_d  = StPulse;
              set_d    = 1'b1;
              cnt_load = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StPulse: begin
        if (cnt_zero) begin
          state_d  = StRecov;
          clr_d    = 1'b0;
          set_d    = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = RECOV_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StRecov: begin
        if (cnt_zero) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StLoad: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      set_q   <= 1'b0;
      ld_q    <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
      set_q   <= set_d;
      ld_q    <= ld_d;
      d_q     <= d_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign clr_o  = clr_q;
  assign set_o  = set_q;
  assign ld_o   = ld_q;
  assign d_o    = d_q;

`ifdef CLRSET_PULSER_STAT_EN
  logic [CNT_W-1:0] stat_q;

  // Counts alongside done_o and saturates at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_q <= '0;
    end else if (done_d && (stat_q != '1)) begin
      stat_q <= stat_q + CNT_W'(1);
    end
  end

  assign cnt_o = stat_q;
`else
  assign cnt_o = '0;
`endif

endmodule
